// File: rtl/cop_dispatch.sv
// cop_dispatch: CPU-to-coprocessor dispatcher (in: clk, rst, instr_valid/instr, mem_rvalid/mem_rdata; out: instr_ready, opcode, addr_reg_in1/in2/destination, write_data_enable, inputdata_float, busy, illegal, load_timeout)
module cop_dispatch #(
  parameter int MEM_TIMEOUT = 15,
  parameter int EXEC_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  opcode,
  output logic [4:0]  addr_reg_in1,
  output logic [4:0]  addr_reg_in2,
  output logic [4:0]  addr_destination,
  output logic        write_data_enable,
  output logic [31:0] inputdata_float,
  output logic        busy,
  output logic        illegal,
  output logic        load_timeout
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam int GW = EXEC_GAP > 1 ? $clog2(EXEC_GAP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] G_LAST = GW'(EXEC_GAP > 0 ? EXEC_GAP - 1 : 0);
  typedef enum logic [1:0] {IDLE, EXEC, LOAD_WAIT, GAP} state_t;
  state_t state_q;
  logic [TW-1:0] tcnt_q;
  logic [GW-1:0] gcnt_q;
  logic [4:0] lw_reg_q;
  logic [5:0] op;
  logic is_exec, is_lw, is_ill, gap_op, unused_bits;
  assign op = instr[31:26];
  assign is_lw = op == 6'b110111;
  assign is_exec = (op[5:3] == 3'b110 && !is_lw) || op == 6'b111000;
  assign is_ill = op[5:3] == 3'b111 && op[2:0] != 3'b000;
  assign gap_op = opcode == 6'b110010 || opcode == 6'b110011 || opcode == 6'b110101;
  assign instr_ready = state_q == IDLE && !rst;
  assign unused_bits = ^instr[10:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      gcnt_q <= '0;
      lw_reg_q <= '0;
      opcode <= '0;
      addr_reg_in1 <= '0;
      addr_reg_in2 <= '0;
      addr_destination <= '0;
      write_data_enable <= 1'b0;
      inputdata_float <= '0;
      busy <= 1'b0;
      illegal <= 1'b0;
      load_timeout <= 1'b0;
    end else begin
      opcode <= '0;
      write_data_enable <= 1'b0;
      illegal <= 1'b0;
      load_timeout <= 1'b0;
      case (state_q)
        IDLE: if (instr_valid) begin
          if (is_exec) begin
            opcode <= op;
            addr_reg_in1 <= instr[25:21];
            addr_reg_in2 <= instr[20:16];
            addr_destination <= instr[15:11];
            busy <= 1'b1;
            state_q <= EXEC;
          end else if (is_lw) begin
            lw_reg_q <= instr[25:21];
            tcnt_q <= '0;
            busy <= 1'b1;
            state_q <= LOAD_WAIT;
          end else if (is_ill) begin
            illegal <= 1'b1;
          end
        end
        EXEC: if (gap_op && EXEC_GAP > 0) begin
          gcnt_q <= G_LAST;
          state_q <= GAP;
        end else begin
          busy <= 1'b0;
          state_q <= IDLE;
        end
        GAP: if (gcnt_q == '0) begin
          busy <= 1'b0;
          state_q <= IDLE;
        end else begin
          gcnt_q <= gcnt_q - 1'b1;
        end
        LOAD_WAIT: if (mem_rvalid) begin
          write_data_enable <= 1'b1;
          inputdata_float <= mem_rdata;
          addr_reg_in1 <= lw_reg_q;
          busy <= 1'b0;
          state_q <= IDLE;
        end else if (tcnt_q == T_LAST) begin
          load_timeout <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cop_dispatch.sv
// tb_cop_dispatch: scoreboard bench for cop_dispatch with a transaction-level timing model
module tb_cop_dispatch;
  localparam int MT = 15, EG = 2;
  logic clk = 0, rst = 1, instr_valid = 0, mem_rvalid = 0;
  logic [31:0] instr = 0, mem_rdata = 0;
  logic instr_ready, write_data_enable, busy, illegal, load_timeout;
  logic [5:0] opcode;
  logic [4:0] addr_reg_in1, addr_reg_in2, addr_destination;
  logic [31:0] inputdata_float;
  typedef struct packed {
    logic [1:0] kind;
    int cyc;
    logic [5:0] op;
    logic [4:0] a1, a2, ad;
    logic [31:0] data;
  } ev_t;
  ev_t q[$];
  ev_t act, x;
  bit exp_busy[int];
  int cyc = 0, free_edge = 0, checks = 0, errs = 0, nev;
  bit mon_en = 0;
  logic [46:0] hold = 0;
  logic [4:0] p_a1 = 0, p_a2 = 0, p_ad = 0;
  logic [31:0] p_data = 0;
  cop_dispatch #(.MEM_TIMEOUT(MT), .EXEC_GAP(EG)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .opcode(opcode),
    .addr_reg_in1(addr_reg_in1), .addr_reg_in2(addr_reg_in2), .addr_destination(addr_destination),
    .write_data_enable(write_data_enable), .inputdata_float(inputdata_float),
    .busy(busy), .illegal(illegal), .load_timeout(load_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask
  function automatic ev_t mk(input logic [1:0] k, input int c, input logic [5:0] o);
    ev_t v;
    v.kind = k; v.cyc = c; v.op = o;
    v.a1 = p_a1; v.a2 = p_a2; v.ad = p_ad; v.data = p_data;
    return v;
  endfunction
  always @(negedge clk) if (mon_en) begin
    nev = int'(opcode != 0) + int'(write_data_enable) + int'(illegal) + int'(load_timeout);
    chk("single_event", nev > 1, 0);
    chk("busy", busy, exp_busy.exists(cyc));
    if (nev > 0) begin
      act.kind = write_data_enable ? 2'd1 : illegal ? 2'd2 : load_timeout ? 2'd3 : 2'd0;
      act.cyc = cyc; act.op = opcode; act.a1 = addr_reg_in1; act.a2 = addr_reg_in2;
      act.ad = addr_destination; act.data = inputdata_float;
      checks++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected event kind=%0d cyc=%0d op=%b, expected none", act.kind, cyc, opcode);
      end else begin
        x = q.pop_front();
        if (act !== x) begin
          errs++;
          $display("FAIL event: got kind=%0d cyc=%0d op=%b a=%0d/%0d/%0d d=%h, expected kind=%0d cyc=%0d op=%b a=%0d/%0d/%0d d=%h",
                   act.kind, act.cyc, act.op, act.a1, act.a2, act.ad, act.data,
                   x.kind, x.cyc, x.op, x.a1, x.a2, x.ad, x.data);
        end
        hold = {x.a1, x.a2, x.ad, x.data};
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      errs++;
      x = q.pop_front();
      $display("FAIL missed event: got none at cycle %0d, expected kind=%0d cyc=%0d", cyc, x.kind, x.cyc);
      hold = {x.a1, x.a2, x.ad, x.data};
    end else begin
      chk("hold", {addr_reg_in1, addr_reg_in2, addr_destination, inputdata_float}, hold);
    end
  end
  task automatic do_reset();
    rst = 1; instr_valid = 0;
    @(negedge clk); chk("ready_in_reset", instr_ready, 0);
    @(posedge clk); #1;
    rst = 0; q.delete();
    p_a1 = 0; p_a2 = 0; p_ad = 0; p_data = 0; hold = 0;
    for (int c = cyc; c < cyc + MT + EG + 8; c++) if (exp_busy.exists(c)) exp_busy.delete(c);
    free_edge = cyc + 1; mon_en = 1;
  endtask
  task automatic issue(input logic [31:0] w, input int d, input logic [31:0] rd);
    int e, fin, o;
    o = int'(w[31:26]);
    e = cyc + 1 > free_edge ? cyc + 1 : free_edge;
    instr_valid = 1; instr = w;
    while (cyc + 1 < e) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk); chk("ready_hold", instr_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk); chk("ready_accept", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 0; instr = $urandom; mem_rvalid = 0;
    if ((o >= 48 && o <= 54) || o == 56) begin
      p_a1 = w[25:21]; p_a2 = w[20:16]; p_ad = w[15:11];
      q.push_back(mk(2'd0, e, w[31:26]));
      fin = (o == 50 || o == 51 || o == 53) ? e + EG : e;
      for (int c = e; c <= fin; c++) exp_busy[c] = 1;
      free_edge = fin + 2;
    end else if (o == 55) begin
      fin = d > 0 ? e + d : e + MT;
      for (int c = e; c < fin; c++) exp_busy[c] = 1;
      if (d > 0) begin
        p_a1 = w[25:21]; p_data = rd;
        q.push_back(mk(2'd1, fin, 6'd0));
      end else q.push_back(mk(2'd3, fin, 6'd0));
      free_edge = fin + 1;
      if (d >= 0) for (int j = 1; j <= fin - e; j++) begin
        mem_rvalid = j == d;
        mem_rdata = j == d ? rd : $urandom;
        @(posedge clk); #1;
      end
      mem_rvalid = 0;
    end else begin
      if (o >= 57) q.push_back(mk(2'd2, e, 6'd0));
      free_edge = e + 1;
    end
  endtask
  initial begin
    logic [31:0] w;
    int d;
    @(posedge clk); #1;
    do_reset();
    issue(32'hC0221800, 0, 0);
    issue({6'b110010, 5'd4, 5'd6, 5'd7, 11'd0}, 0, 0);
    issue(32'hC0221800, 0, 0);
    issue(32'hDCA00000, 3, 32'h40490FDB);
    issue({6'b110111, 5'd9, 21'd0}, 0, 0);
    issue({6'b110111, 5'd10, 21'd0}, MT, 32'h3F800000);
    issue(32'hE8000000, 0, 0);
    issue(32'h10000000, 0, 0);
    issue({6'b110111, 5'd12, 21'd0}, -1, 0);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[31:30] = 2'b11;
      d = $urandom_range(0, MT);
      if ($urandom_range(0, 19) == 0) do_reset();
      repeat ($urandom_range(0, 2)) begin
        mem_rvalid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      mem_rvalid = 0;
      issue(w, d, $urandom);
    end
    repeat (25) @(posedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
